// File: rtl/mem_responder.sv
// mem_responder: fixed-latency memory responder for the CPU readM/writeM/address/data bus.
// One request at a time; reads complete with inputReady, writes commit then raise ackOutput.
module mem_responder #(
  parameter int WORD_SIZE     = 16,
  parameter int ADDR_BITS     = 8,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 readM,
  input  logic                 writeM,
  input  logic [WORD_SIZE-1:0] address,
  inout  wire  [WORD_SIZE-1:0] data,
  output logic                 inputReady,
  output logic                 ackOutput,
  output logic                 conflict
);
  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_DONE, WR_WAIT, WR_DONE} state_t;
  state_t               state;
  logic [3:0]           counter;
  logic [ADDR_BITS-1:0] rd_addr;
  logic [ADDR_BITS-1:0] wr_addr;
  logic [WORD_SIZE-1:0] wr_data;
  logic [WORD_SIZE-1:0] mem [2**ADDR_BITS];
  logic                 addr_unused;
  assign addr_unused = ^address[WORD_SIZE-1:ADDR_BITS];
  // inputReady is high exactly in RD_DONE, so it doubles as the bus drive enable
  assign data = inputReady ? mem[rd_addr] : 'z;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      counter    <= '0;
      inputReady <= 1'b0;
      ackOutput  <= 1'b0;
      conflict   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (readM) begin
            rd_addr    <= address[ADDR_BITS-1:0];
            conflict   <= conflict | writeM;
            counter    <= 4'(READ_LATENCY - 1);
            state      <= (READ_LATENCY == 1) ? RD_DONE : RD_WAIT;
            inputReady <= (READ_LATENCY == 1);
          end else if (writeM) begin
            wr_addr   <= address[ADDR_BITS-1:0];
            wr_data   <= data;
            counter   <= 4'(WRITE_LATENCY - 1);
            state     <= (WRITE_LATENCY == 1) ? WR_DONE : WR_WAIT;
            ackOutput <= (WRITE_LATENCY == 1);
            if (WRITE_LATENCY == 1) mem[address[ADDR_BITS-1:0]] <= data;
          end
        end
        RD_WAIT: begin
          counter    <= counter - 4'd1;
          state      <= !readM ? IDLE : (counter == 4'd1) ? RD_DONE : RD_WAIT;
          inputReady <= readM && counter == 4'd1;
        end
        RD_DONE: begin
          if (!readM) begin
            state      <= IDLE;
            inputReady <= 1'b0;
          end
        end
        WR_WAIT: begin
          counter   <= counter - 4'd1;
          state     <= !writeM ? IDLE : (counter == 4'd1) ? WR_DONE : WR_WAIT;
          ackOutput <= writeM && counter == 4'd1;
          if (writeM && counter == 4'd1) mem[wr_addr] <= wr_data;
        end
        WR_DONE: begin
          if (!writeM) begin
            state     <= IDLE;
            ackOutput <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
